// File: rtl/uart_frame_pkg.sv
// Shared definitions for the "&&payload&&" string framing protocol,
// used by both the receive-side deframer and the transmit-side framer.
package uart_frame_pkg;

    localparam logic [7:0] FRAME_SIGN      = 8'h26;
    localparam int         DEF_MAX_LEN     = 137;
    localparam int         DEF_TIMEOUT_CYC = 50_000;

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        SOF1 = 5'b00010,
        DATA = 5'b00100,
        EOF1 = 5'b01000,
        HOLD = 5'b10000
    } frame_state_t;

    function automatic logic is_sign(input logic [7:0] b);
        return b == FRAME_SIGN;
    endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port payload buffer: one write port, one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module frame_buf_ram #(
    parameter int DEPTH = 137,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_rdata <= 8'h00;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_frame_rx.sv
// Receive-side deframer: strips the &&...&& delimiters from the uart_rx byte
// stream and holds the payload in a buffer until the application acks it.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_vld,
    output logic       frm_vld,
    output logic [7:0] frm_len,
    input  logic       frm_ack,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rx_busy,
    output logic       err_ovf,
    output logic       err_tmo,
    output logic       err_drop
);

    localparam int         TW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit         TMO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [8:0] MAX_IDX  = 9'(MAX_LEN);

    frame_state_t  r_state, w_state_next;
    logic [7:0]    r_len, w_len_next;
    logic [7:0]    r_frm_len, w_frm_len_next;
    logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_next;
    logic          r_err_ovf, w_err_ovf_next;
    logic          r_err_tmo, w_err_tmo_next;
    logic          r_err_drop, w_err_drop_next;

    logic          w_busy;
    logic          w_sign;
    logic          w_tmo_hit;
    logic          w_we;
    logic [8:0]    w_wr_idx;
    logic [7:0]    w_wr_addr;

    assign w_busy    = (r_state == SOF1) || (r_state == DATA) || (r_state == EOF1);
    assign w_sign    = is_sign(rx_data);
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign w_tmo_hit = TMO_EN && w_busy && !rx_vld && (r_tmo_cnt == TMO_LAST);
    assign w_wr_addr = w_wr_idx[7:0];

    always_comb begin
        w_state_next    = r_state;
        w_len_next      = r_len;
        w_frm_len_next  = r_frm_len;
        w_err_ovf_next  = 1'b0;
        w_err_tmo_next  = 1'b0;
        w_err_drop_next = 1'b0;
        w_we            = 1'b0;
        w_wr_idx        = {1'b0, r_len};

        if (!TMO_EN || !w_busy || rx_vld || w_tmo_hit) begin
            w_tmo_cnt_next = '0;
        end else begin
            w_tmo_cnt_next = r_tmo_cnt + TW'(1);
        end

        unique case (r_state)
            IDLE: begin
                if (rx_vld && w_sign) begin
                    w_state_next = SOF1;
                end
            end
            SOF1: begin
                if (rx_vld) begin
                    if (w_sign) begin
                        w_state_next = DATA;
                        w_len_next   = 8'd0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            DATA: begin
                // A '&' is stored tentatively at buf[len]; EOF1 decides whether it stays.
                if (rx_vld) begin
                    if (w_wr_idx >= MAX_IDX) begin
                        w_err_ovf_next = 1'b1;
                        w_state_next   = IDLE;
                    end else begin
                        w_we = 1'b1;
                        if (w_sign) begin
                            w_state_next = EOF1;
                        end else begin
                            w_len_next = r_len + 8'd1;
                        end
                    end
                end
            end
            EOF1: begin
                if (rx_vld) begin
                    if (w_sign) begin
                        w_state_next   = HOLD;
                        w_frm_len_next = r_len;
                    end else begin
                        w_wr_idx = {1'b0, r_len} + 9'd1;
                        if (w_wr_idx >= MAX_IDX) begin
                            w_err_ovf_next = 1'b1;
                            w_state_next   = IDLE;
                        end else begin
                            w_we         = 1'b1;
                            w_len_next   = r_len + 8'd2;
                            w_state_next = DATA;
                        end
                    end
                end
            end
            HOLD: begin
                w_err_drop_next = rx_vld;
                if (frm_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_tmo_hit) begin
            w_err_tmo_next = 1'b1;
            w_state_next   = IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_len      <= 8'd0;
            r_frm_len  <= 8'd0;
            r_tmo_cnt  <= '0;
            r_err_ovf  <= 1'b0;
            r_err_tmo  <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_len      <= w_len_next;
            r_frm_len  <= w_frm_len_next;
            r_tmo_cnt  <= w_tmo_cnt_next;
            r_err_ovf  <= w_err_ovf_next;
            r_err_tmo  <= w_err_tmo_next;
            r_err_drop <= w_err_drop_next;
        end
    end

    frame_buf_ram #(
        .DEPTH (MAX_LEN),
        .AW    (8)
    ) u_buf (
        .clk     (sys_clk),
        .srst    (sys_rst),
        .i_we    (w_we),
        .i_waddr (w_wr_addr),
        .i_wdata (rx_data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign frm_vld  = (r_state == HOLD);
    assign frm_len  = r_frm_len;
    assign rx_busy  = w_busy;
    assign err_ovf  = r_err_ovf;
    assign err_tmo  = r_err_tmo;
    assign err_drop = r_err_drop;

endmodule
